// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM state encoding,
// R/W bit values and the byte length used by the bit counter.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_NA,
    ST_IGNORE
  } sccb_rsp_state_t;

  localparam logic       SCCB_WR_BIT   = 1'b0;
  localparam logic       SCCB_RD_BIT   = 1'b1;
  localparam logic [3:0] SCCB_BYTE_LEN = 4'd8;

endpackage

// File: rtl/sccb_line_sync.sv
// Brings the asynchronous SIOC/SIOD lines into clk_i and derives the bus
// events (SIOC edges, START, STOP) from the synchronized values.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sioc_i,
  input  logic siod_i,
  output logic sioc_rise_o,
  output logic sioc_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic siod_s_o
);

  logic [SYNC_STAGES-1:0] r_sioc_sync;
  logic [SYNC_STAGES-1:0] r_siod_sync;
  logic                   r_sioc_d;
  logic                   r_siod_d;
  logic                   w_sioc_s;
  logic                   w_siod_s;

  // Both lines idle high, so resetting to 1 avoids a false edge at release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sioc_sync <= '1;
      r_siod_sync <= '1;
      r_sioc_d    <= 1'b1;
      r_siod_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_sioc_sync <= {r_sioc_sync[SYNC_STAGES-2:0], sioc_i};
      r_siod_sync <= {r_siod_sync[SYNC_STAGES-2:0], siod_i};
      r_sioc_d    <= w_sioc_s;
      r_siod_d    <= w_siod_s;
    end
  end

  assign w_sioc_s    = r_sioc_sync[SYNC_STAGES-1];
  assign w_siod_s    = r_siod_sync[SYNC_STAGES-1];
  assign sioc_rise_o = w_sioc_s & ~r_sioc_d;
  assign sioc_fall_o = ~w_sioc_s & r_sioc_d;
  assign start_det_o = w_sioc_s & r_sioc_d & ~w_siod_s & r_siod_d;
  assign stop_det_o  = w_sioc_s & r_sioc_d & w_siod_s & ~r_siod_d;
  assign siod_s_o    = w_siod_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes ID / sub-address / data phases from an SCCB master
// and maps them onto a simple register-file port with write/read strobes.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sioc_i,
  input  logic       siod_i,
  output logic       siod_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  localparam logic [7:0] WR_ID = {DEV_ID[7:1], SCCB_WR_BIT};
  localparam logic [7:0] RD_ID = {DEV_ID[7:1], SCCB_RD_BIT};

  sccb_rsp_state_t r_state, w_state_nx;
  logic [3:0] r_cnt;
  logic [7:0] r_sh;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_oe, r_we, r_re, r_ld, r_ld_drive, r_wr_done;

  logic       w_sioc_rise, w_sioc_fall, w_start, w_stop, w_siod_s;
  logic       w_byte_done, w_ack_end;
  logic [7:0] w_byte;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sioc_i      (sioc_i),
    .siod_i      (siod_i),
    .sioc_rise_o (w_sioc_rise),
    .sioc_fall_o (w_sioc_fall),
    .start_det_o (w_start),
    .stop_det_o  (w_stop),
    .siod_s_o    (w_siod_s)
  );

  assign w_byte      = {r_sh[6:0], w_siod_s};
  assign w_byte_done = w_sioc_rise && (r_cnt == SCCB_BYTE_LEN - 4'd1);
  // In an ACK state r_oe doubles as the phase marker: set on the first fall.
  assign w_ack_end   = w_sioc_fall && r_oe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    w_state_nx = r_state;
    if (w_stop) begin
      w_state_nx = ST_IDLE;
    end else if (w_start) begin
      w_state_nx = ST_ID;
    end else begin
      case (r_state)
        ST_ID:        if (w_byte_done)
                        w_state_nx = (w_byte == WR_ID || w_byte == RD_ID) ? ST_ID_ACK : ST_IGNORE;
        ST_ID_ACK:    if (w_ack_end)
                        w_state_nx = (r_sh[0] == SCCB_RD_BIT) ? ST_RDATA : ST_SUB;
        ST_SUB:       if (w_byte_done) w_state_nx = ST_SUB_ACK;
        ST_SUB_ACK,
        ST_WDATA_ACK: if (w_ack_end)   w_state_nx = ST_WDATA;
        ST_WDATA:     if (w_byte_done) w_state_nx = ST_WDATA_ACK;
        ST_RDATA:     if (w_byte_done) w_state_nx = ST_RD_NA;
        ST_RD_NA:     if (w_sioc_rise) w_state_nx = w_siod_s ? ST_IGNORE : ST_RDATA;
        default:      w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= 4'd0;
      r_sh       <= 8'h00;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
      r_oe       <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_ld       <= 1'b0;
      r_ld_drive <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      r_ld <= r_re;
      if (w_stop || w_start) begin
        r_oe  <= 1'b0;
        r_cnt <= 4'd0;
        r_sh  <= 8'h00;
        r_ld  <= 1'b0;
      end else begin
        case (r_state)
          ST_ID, ST_SUB, ST_WDATA: begin
            if (w_sioc_rise) begin
              r_sh  <= w_byte;
              r_cnt <= w_byte_done ? 4'd0 : r_cnt + 4'd1;
              if (w_byte_done && r_state == ST_SUB) r_addr <= w_byte;
              // Pointer advances only when a further byte lands, so it names the last write.
              if (w_byte_done && r_state == ST_WDATA) begin
                r_wdata   <= w_byte;
                r_we      <= 1'b1;
                r_wr_done <= 1'b1;
                if (r_wr_done) r_addr <= r_addr + 8'd1;
              end
            end
          end
          ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
            if (w_sioc_fall) begin
              r_oe <= ~r_oe;
              if (r_oe && r_state == ST_ID_ACK && r_sh[0] == SCCB_RD_BIT) begin
                r_re       <= 1'b1;
                r_ld_drive <= 1'b1;
              end
              if (r_oe && r_state == ST_SUB_ACK) r_wr_done <= 1'b0;
            end
          end
          ST_RDATA: begin
            if (r_ld) begin
              r_sh <= reg_rdata_i;
              if (r_ld_drive) r_oe <= ~reg_rdata_i[7];
            end else if (w_sioc_rise) begin
              r_cnt <= w_byte_done ? 4'd0 : r_cnt + 4'd1;
            end else if (w_sioc_fall) begin
              if (r_cnt == 4'd0) begin
                r_oe <= ~r_sh[7];
              end else begin
                r_sh <= {r_sh[6:0], 1'b0};
                r_oe <= ~r_sh[6];
              end
            end
          end
          ST_RD_NA: begin
            if (w_sioc_fall) begin
              r_oe <= 1'b0;
            end else if (w_sioc_rise && !w_siod_s) begin
              r_re       <= 1'b1;
              r_ld_drive <= 1'b0;
              r_addr     <= r_addr + 8'd1;
            end
          end
          default: r_oe <= 1'b0;
        endcase
      end
    end
  end

  assign siod_oe_o   = r_oe;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = r_we;
  assign reg_re_o    = r_re;
  assign busy_o      = (r_state != ST_IDLE);

endmodule
